mux3_rr_arbiter: RTL and testbench
==================================

Name: mux3_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 3:1 select path.
- Three requesters compete for one output stream. The block grants one at a time and drives the 2-bit mux select (s1,s0) to the granted source.
- Forwards that source's data and last flag with a valid/ready handshake.
- Bursts hold the grant until last, until the requester drops req, or until a MAX_HOLD beat cap; ownership then rotates fairly.

Parameters:
DW, 8, data width of each requester input and of the output.
MAX_HOLD, 4, max beats one owner may transfer per grant before forced release (legal range 1..255).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  3  per-requester request; bit i = requester i.
last  input  3  per-requester end-of-burst flag; valid with req[i].
d0  input  DW  requester 0 data.
d1  input  DW  requester 1 data.
d2  input  DW  requester 2 data.
out_ready  input  1  downstream accepts beat.
gnt  output  3  one-hot grant, registered.
s1  output  1  mux select high bit, registered.
s0  output  1  mux select low bit, registered.
out_valid  output  1  beat available = BUSY & req[owner].
out_data  output  DW  selected data: s1 ? d2 : (s0 ? d1 : d0).
out_last  output  1  last[owner] when BUSY, else 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, gnt = 000, s1/s0 = 0/0, beat_cnt = 0, out_valid = 0, out_last = 0.
  - last-owner pointer ptr = 2, so requester 0 has top priority first.
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, choose the first set bit scanning ptr+1, ptr+2, ptr+3 (mod 3).
  - Next edge: gnt = onehot(winner), sel = winner encoding, state = BUSY, beat_cnt = 0.
  - Winner encoding: 0 → s1s0 = 00, 1 → 01, 2 → 10. Encoding 11 is never driven.
  - If req == 0, stay IDLE; gnt = 000; s1/s0 hold their previous value.
- Grant latency: req rising in IDLE at edge N → gnt/sel valid after edge N+1. out_valid can be high in cycle N+1.
- BUSY:
  - out_valid = req[owner]; out_data/out_last are combinational from the current sel.
  - Beat = out_valid & out_ready; each beat increments beat_cnt.
- Release from BUSY to IDLE at the next edge, with gnt = 000 and ptr = owner, when any of:
  - (a) a beat with out_last = 1;
  - (b) a beat with beat_cnt == MAX_HOLD-1 (forced release, last not required);
  - (c) req[owner] == 0 (abort; no beat occurs that cycle).
- Bubble: exactly one IDLE cycle between consecutive grants. A back-to-back owner change takes 2 cycles.
- Non-owner req changes during BUSY are ignored. Owner last without req is ignored.
- out_ready low stalls: state, beat_cnt, and sel hold; data must stay stable (requester rule).
- Simultaneous requests in IDLE resolve strictly by rotation from ptr; no requester waits more than 2 grants.
- rst during BUSY: next edge returns to the reset values. Any beat accepted in that same cycle is still counted as transferred downstream; the block just drops ownership.
- beat_cnt width is 8 bits. It never wraps, because release occurs at MAX_HOLD-1.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then req=000 for 5 cycles → gnt=000, s1s0=00, out_valid=0 throughout.
- Single burst: req=001, d0=A5, last on 3rd beat, out_ready=1.
  - gnt=001 one cycle after req.
  - 3 beats with out_data=A5; out_last high on beat 3.
  - gnt=000 on the next cycle.
- Round robin: req=111 held, each burst 1 beat with last=1.
  - Grant order 0,1,2,0 with s1s0 = 00,01,10,00.
  - One idle cycle between grants.
- Forced release: MAX_HOLD=4, req=010 with last never set, out_ready=1.
  - Exactly 4 beats, then gnt=000.
  - If req=110 is held, the next grant goes to 2, not 1.
- Stall and abort:
  - Owner 2 with out_ready=0 for 3 cycles → beat_cnt, gnt, and s1s0=10 hold.
  - Owner then drops req → gnt=000 next cycle with no beat; ptr=2, so req=011 grants 0.
- Reset mid-burst: assert rst on beat 2 of a 4-beat burst from requester 1 → next cycle gnt=000, s1s0=00, and requester 0 wins the next tie.

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 3:1 select path.
// One owner at a time drives the output stream; bursts end on last, on a
// beat cap (MAX_HOLD) or when the owner drops req, then ownership rotates.
module mux3_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [2:0]    last,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic          out_ready,
  output logic [2:0]    gnt,
  output logic          s1,
  output logic          s0,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_n;
  logic [2:0] gnt_q, gnt_n;
  logic [1:0] sel, sel_n;        // {s1,s0}, also the owner index while BUSY
  logic [1:0] ptr, ptr_n;        // last owner; search starts just after it
  logic [7:0] beat_cnt, cnt_n;
  logic [1:0] c1, c2, win;
  logic       beat;

  localparam logic [7:0] CAP = 8'(MAX_HOLD - 1);

  // Next requester index in rotation order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] oh(input logic [1:0] p);
    return 3'b001 << p;
  endfunction

  // gnt is one-hot while BUSY and zero in IDLE, so masking with it picks the owner.
  assign out_valid = (state == BUSY) && |(req & gnt_q);
  assign out_last  = (state == BUSY) && |(last & gnt_q);
  assign out_data  = sel[1] ? d2 : (sel[0] ? d1 : d0);
  assign beat      = out_valid & out_ready;
  assign gnt       = gnt_q;
  assign s1        = sel[1];
  assign s0        = sel[0];

  // Rotating priority: ptr+1 first, ptr itself last.
  always_comb begin
    c1  = nxt(ptr);
    c2  = nxt(c1);
    win = |(req & oh(c1)) ? c1 : (|(req & oh(c2)) ? c2 : ptr);
  end

  // Next-state logic: grant in IDLE, count beats and decide release in BUSY.
  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = beat_cnt;
    unique case (state)
      IDLE: begin
        gnt_n = 3'b000;
        if (|req) begin
          state_n = BUSY;
          gnt_n   = oh(win);
          sel_n   = win;
          cnt_n   = 8'd0;
        end
      end
      BUSY: begin
        if (!(|(req & gnt_q)) || (beat && (out_last || beat_cnt == CAP))) begin
          state_n = IDLE;
          gnt_n   = 3'b000;
          ptr_n   = sel;
          cnt_n   = 8'd0;
        end else if (beat) begin
          cnt_n = beat_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset gives requester 0 first priority (ptr = 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= 3'b000;
      sel      <= 2'b00;
      ptr      <= 2'd2;
      beat_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      gnt_q    <= gnt_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      beat_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: reset, single burst, rotation,
// forced release, stall/abort and reset mid-burst.
module tb_mux3_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] last = 3'b000;
  logic [7:0] d0 = 8'hA5, d1 = 8'h3C, d2 = 8'hE1;
  logic       out_ready = 1'b1;
  logic [2:0] gnt;
  logic       s1, s0, out_valid, out_last;
  logic [7:0] out_data;
  int         passed = 0;
  int         total  = 0;

  mux3_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .d0(d0), .d1(d1), .d2(d2),
    .out_ready(out_ready), .gnt(gnt), .s1(s1), .s0(s0),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'b000; last = 3'b000; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (gnt !== 3'b000) $display("FAIL reset_gnt cyc%0d got %b exp 000", i, gnt); else passed++;
      total++; if ({s1, s0} !== 2'b00) $display("FAIL reset_sel cyc%0d got %b exp 00", i, {s1, s0}); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got %b exp 0", i, out_valid); else passed++;
      tick();
    end
  endtask

  task automatic test_single_burst();
    d0 = 8'hA5; req = 3'b001; last = 3'b000; out_ready = 1'b1;
    tick();
    for (int b = 1; b <= 3; b++) begin
      if (b == 3) begin last = 3'b001; #1; end
      total++; if (gnt !== 3'b001) $display("FAIL single_gnt beat%0d got %b exp 001", b, gnt); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL single_valid beat%0d got %b exp 1", b, out_valid); else passed++;
      total++; if (out_data !== 8'hA5) $display("FAIL single_data beat%0d got %h exp a5", b, out_data); else passed++;
      total++; if (out_last !== (b == 3)) $display("FAIL single_last beat%0d got %b exp %b", b, out_last, b == 3); else passed++;
      tick();
    end
    req = 3'b000; last = 3'b000; #1;
    total++; if (gnt !== 3'b000) $display("FAIL single_release got %b exp 000", gnt); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL single_idle_valid got %b exp 0", out_valid); else passed++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [1:0] exp_s [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_s[0] = 2'b00;  exp_s[1] = 2'b01;  exp_s[2] = 2'b10;  exp_s[3] = 2'b00;
    do_reset();
    req = 3'b111; last = 3'b111; d1 = 8'h3C; d2 = 8'hE1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (gnt !== exp_g[k]) $display("FAIL rr_gnt%0d got %b exp %b", k, gnt, exp_g[k]); else passed++;
      total++; if ({s1, s0} !== exp_s[k]) $display("FAIL rr_sel%0d got %b exp %b", k, {s1, s0}, exp_s[k]); else passed++;
      total++; if (out_last !== 1'b1) $display("FAIL rr_last%0d got %b exp 1", k, out_last); else passed++;
      tick();
      total++; if (gnt !== 3'b000) $display("FAIL rr_bubble%0d got %b exp 000", k, gnt); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rr_bubble_valid%0d got %b exp 0", k, out_valid); else passed++;
    end
    req = 3'b000; last = 3'b000;
    tick();
  endtask

  // Forced release of owner 1 after 4 beats, then owner 2 stalls and aborts.
  task automatic test_forced_stall_abort();
    do_reset();
    req = 3'b110; last = 3'b000; out_ready = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      total++; if (gnt !== 3'b010) $display("FAIL forced_gnt beat%0d got %b exp 010", b, gnt); else passed++;
      total++; if (out_data !== 8'h3C) $display("FAIL forced_data beat%0d got %h exp 3c", b, out_data); else passed++;
      tick();
    end
    total++; if (gnt !== 3'b000) $display("FAIL forced_release got %b exp 000", gnt); else passed++;
    tick();
    total++; if (gnt !== 3'b100) $display("FAIL forced_next_gnt got %b exp 100", gnt); else passed++;
    total++; if ({s1, s0} !== 2'b10) $display("FAIL forced_next_sel got %b exp 10", {s1, s0}); else passed++;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (gnt !== 3'b100) $display("FAIL stall_gnt cyc%0d got %b exp 100", c, gnt); else passed++;
      total++; if ({s1, s0} !== 2'b10) $display("FAIL stall_sel cyc%0d got %b exp 10", c, {s1, s0}); else passed++;
    end
    // Three beats leave the count at 3 (below the cap), so ownership remains.
    out_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (gnt !== 3'b100) $display("FAIL stall_cnt_held got %b exp 100", gnt); else passed++;
    req = 3'b011; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL abort_valid got %b exp 0", out_valid); else passed++;
    tick();
    total++; if (gnt !== 3'b000) $display("FAIL abort_release got %b exp 000", gnt); else passed++;
    tick();
    total++; if (gnt !== 3'b001) $display("FAIL abort_next_gnt got %b exp 001", gnt); else passed++;
    req = 3'b000;
    tick(); tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 3'b010; last = 3'b000; out_ready = 1'b1;
    tick();
    total++; if (gnt !== 3'b010) $display("FAIL rstmid_gnt got %b exp 010", gnt); else passed++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 3'b011; #1;
    total++; if (gnt !== 3'b000) $display("FAIL rstmid_release got %b exp 000", gnt); else passed++;
    total++; if ({s1, s0} !== 2'b00) $display("FAIL rstmid_sel got %b exp 00", {s1, s0}); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", out_valid); else passed++;
    tick();
    total++; if (gnt !== 3'b001) $display("FAIL rstmid_tie got %b exp 001", gnt); else passed++;
    req = 3'b000;
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_forced_stall_abort();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
